// File: rtl/sd_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_framer
// Purpose  : Builds the 6-byte SPI-mode SD command frame
//            ({01,index}, 4 argument bytes MSB first, {crc7,1}), sends it to
//            the SPI byte engine, discards the loopback bytes, then polls with
//            FILL_BYTE until an R1 byte (bit 7 clear) arrives or RESP_POLLS
//            polls have gone unanswered.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            cmd_valid_i/ready_o  - command request handshake
//            cmd_index_i/arg_i    - command number and argument
//            tx_valid_o/ready_i   - byte stream towards the SPI input FIFO
//            tx_data_o            - byte to shift out on MOSI
//            rx_valid_i/data_i    - one pulse per byte received on MISO
//            resp_valid_o         - pulse: R1 captured in resp_data_o
//            resp_timeout_o       - pulse: no R1 within RESP_POLLS polls
//            resp_data_o          - last captured response byte
//            busy_o               - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_framer #(
  parameter int unsigned RESP_POLLS = 8,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        resp_valid_o,
  output logic        resp_timeout_o,
  output logic [7:0]  resp_data_o,
  output logic        busy_o
);

  localparam logic [7:0] POLLS_MAX   = RESP_POLLS[7:0];
  localparam logic [2:0] FRAME_LAST  = 3'd5;
  localparam logic [2:0] FRAME_BYTES = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_POLL    = 3'd3,
    ST_WAIT_RX = 3'd4
  } state_t;

  state_t      state_q;
  logic [2:0]  byte_idx_q;
  logic [2:0]  rx_cnt_q;
  logic [7:0]  poll_cnt_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        cmd_ready_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        resp_valid_q;
  logic        resp_timeout_q;
  logic [7:0]  resp_data_q;
  logic [6:0]  crc_next;

  // CRC7 (x^7 + x^3 + 1), one byte folded in MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in,
                                           input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // The CRC is accumulated over each byte as it is handed over, so when
  // byte 4 is accepted crc_next already covers bytes 0..4.
  assign crc_next = crc7_byte(crc_q, tx_data_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      byte_idx_q     <= 3'd0;
      rx_cnt_q       <= 3'd0;
      poll_cnt_q     <= 8'd0;
      arg_q          <= 32'd0;
      crc_q          <= 7'd0;
      cmd_ready_q    <= 1'b1;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= 8'h00;
    end else begin
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;

      // Loopback bytes of the frame are counted in any active state, since
      // some of them arrive while later frame bytes are still being sent.
      if (state_q != ST_IDLE && rx_valid_i && rx_cnt_q != FRAME_BYTES) begin
        rx_cnt_q <= rx_cnt_q + 3'd1;
      end

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            arg_q       <= cmd_arg_i;
            tx_data_q   <= {2'b01, cmd_index_i};
            tx_valid_q  <= 1'b1;
            byte_idx_q  <= 3'd0;
            rx_cnt_q    <= 3'd0;
            poll_cnt_q  <= 8'd0;
            crc_q       <= 7'd0;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_SEND;
          end else begin
            // Held low for the pulse cycle after a response, rises after.
            cmd_ready_q <= 1'b1;
          end
        end

        ST_SEND: begin
          if (tx_ready_i) begin
            crc_q <= crc_next;
            if (byte_idx_q == FRAME_LAST) begin
              tx_valid_q <= 1'b0;
              state_q    <= ST_FLUSH;
            end else begin
              byte_idx_q <= byte_idx_q + 3'd1;
              if (byte_idx_q == 3'd4) begin
                tx_data_q <= {crc_next, 1'b1};
              end else begin
                tx_data_q <= arg_q[31:24];
                arg_q     <= {arg_q[23:0], 8'h00};
              end
            end
          end
        end

        ST_FLUSH: begin
          if (rx_cnt_q == FRAME_BYTES) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= FILL_BYTE;
            state_q    <= ST_POLL;
          end
        end

        ST_POLL: begin
          if (tx_ready_i) begin
            poll_cnt_q <= poll_cnt_q + 8'd1;
            tx_valid_q <= 1'b0;
            state_q    <= ST_WAIT_RX;
          end
        end

        ST_WAIT_RX: begin
          if (rx_valid_i) begin
            resp_data_q <= rx_data_i;
            if (!rx_data_i[7]) begin
              resp_valid_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else if (poll_cnt_q == POLLS_MAX) begin
              resp_timeout_q <= 1'b1;
              state_q        <= ST_IDLE;
            end else begin
              tx_valid_q <= 1'b1;
              state_q    <= ST_POLL;
            end
          end
        end

        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign tx_valid_o     = tx_valid_q;
  assign tx_data_o      = tx_data_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_timeout_o = resp_timeout_q;
  assign resp_data_o    = resp_data_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/sd_cmd_framer.md
SD_CMD_FRAMER -- requirements
Module: sd_cmd_framer

Interface
REQ-001 Parameter RESP_POLLS, default 8: maximum number of 0xFF poll bytes sent while waiting for an R1 response (range 1..255).
REQ-002 Parameter FILL_BYTE, default 8'hFF: byte transmitted during response polling.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request from the SD controller.
REQ-006 cmd_ready  output  1  framer idle and able to accept a command.
REQ-007 cmd_index  input  6  SD command number, 0..63.
REQ-008 cmd_arg  input  32  command argument, transmitted MSB first.
REQ-009 tx_valid  output  1  tx_data holds a byte for the SPI byte engine's input FIFO.
REQ-010 tx_ready  input  1  SPI input FIFO not full; byte accepted when tx_valid&tx_ready.
REQ-011 tx_data  output  8  byte to shift out on MOSI.
REQ-012 rx_valid  input  1  one-cycle pulse, SPI engine delivers one received byte.
REQ-013 rx_data  input  8  received MISO byte, valid with rx_valid.
REQ-014 resp_valid  output  1  one-cycle pulse, R1 response available.
REQ-015 resp_timeout  output  1  one-cycle pulse, no R1 within RESP_POLLS polls.
REQ-016 resp_data  output  8  last captured response byte; held until the next capture.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, SEND, FLUSH, POLL, WAIT_RX; nothing else.
REQ-019 IDLE: cmd_ready=1. On cmd_valid&cmd_ready, capture cmd_index/cmd_arg, clear byte and poll counters, go to SEND. Inputs are ignored after capture.
REQ-020 Frame: 6 bytes in order: {2'b01,cmd_index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1'b1}.
REQ-021 crc7 uses polynomial x^7+x^3+1 with initial value 0, computed over bytes 0..4 MSB first.
REQ-022 SEND: tx_valid=1 starting the cycle after acceptance. On each tx_valid&tx_ready handshake, tx_data advances to the next byte the following cycle. tx_data stays stable while tx_ready=0. After the handshake of byte 5, go to FLUSH.
REQ-023 Every transmitted byte produces exactly one rx_valid. The framer counts rx bytes from acceptance onward, including any that arrive during SEND. The first 6 rx bytes are discarded.
REQ-024 FLUSH: tx_valid=0. Once the 6th rx byte has been counted, go to POLL.
REQ-025 POLL: tx_valid=1 with tx_data=FILL_BYTE. On handshake, increment poll_cnt and go to WAIT_RX.
REQ-026 WAIT_RX: tx_valid=0. On rx_valid, resp_data<=rx_data. Then:
- if rx_data[7]=0: pulse resp_valid for one cycle and return to IDLE;
- else if poll_cnt==RESP_POLLS: pulse resp_timeout for one cycle and return to IDLE;
- else: return to POLL.
REQ-027 Only one poll byte is outstanding at a time, so no poll byte is sent after the response byte.
REQ-028 resp_valid and resp_timeout are never high together. cmd_ready is low in the cycle either pulses; it rises the next cycle.
REQ-029 rx_valid in IDLE, or beyond the expected count, is ignored and changes no output.
REQ-030 Counters: byte index 3 bits, rx count 3 bits, poll_cnt 8 bits. No wrap occurs, because RESP_POLLS<=255.

Reset
REQ-031 While reset is asserted: state=IDLE, cmd_ready=1, tx_valid=0, tx_data=8'h00, resp_valid=0, resp_timeout=0, resp_data=8'h00, busy=0, all counters 0.
REQ-032 Reset asserted mid-frame or mid-poll abandons the command. No response pulse is generated, and the first post-reset command is framed from byte 0.

Verification
REQ-033 CMD0, arg 0, tx_ready=1 -> tx bytes 40 00 00 00 00 95. Loopback rx FF x6, then 01 -> resp_valid with resp_data=0x01 after exactly 1 poll.
REQ-034 CMD8, arg 0x000001AA -> 48 00 00 01 AA 87. CMD55, arg 0 -> 77 00 00 00 00 65. CMD41, arg 0x40000000 -> 69 40 00 00 00 77.
REQ-035 rx always FF, RESP_POLLS=8 -> exactly 8 poll bytes, then resp_timeout pulse with resp_data=0xFF and no resp_valid.
REQ-036 tx_ready toggling 0/1 every other cycle during SEND -> same 6-byte sequence, tx_data stable while stalled, no byte duplicated or skipped.
REQ-037 Reset pulse after byte 3 handshake -> all outputs at reset values. A following CMD0 yields the full 40..95 frame.
REQ-038 cmd_valid held high across a response -> a second command is accepted only the cycle after cmd_ready rises. rx_valid pulses in IDLE produce no output change.
